// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request sequencer with redirect/flush handling.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_CHK_EN.
module pc_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jumpOrBranch,
  input  logic            jalrIn,
  input  logic [XLEN-1:0] brPcIn,
  input  logic [XLEN-1:0] immIn,
  input  logic [XLEN-1:0] rs1In,
  input  logic            stallIn,
  output logic            imemReqValid,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlus4Out,
  output logic            flushOut
`ifdef PC_MISALIGN_CHK_EN
  , output logic          misalignErr
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t          state, nextState;
  logic [XLEN-1:0] target, seqAddr, nextAddr, pendingTarget;
  logic            pending, handshake, held, redirect;

  assign target = jalrIn ? ((rs1In + immIn) & {{(XLEN-1){1'b1}}, 1'b0})
                         : (brPcIn + immIn);
  assign seqAddr      = imemReqAddr + XLEN'(4);
  assign imemReqValid = (state == REQ);
  assign handshake    = imemReqValid & imemReqReady;
  assign held         = imemReqValid & ~imemReqReady;

`ifdef PC_MISALIGN_CHK_EN
  // A target with bit 1 set is dropped entirely: no flush, fetch carries on.
  assign redirect = jumpOrBranch & ~target[1];
`else
  assign redirect = jumpOrBranch;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      BOOT: nextState = REQ;
      REQ:  if (handshake && stallIn) nextState = WAIT;
      WAIT: if (!stallIn) nextState = REQ;
      default: nextState = BOOT;
    endcase
  end

  // A presented request keeps its address until accepted; redirects meanwhile go to pending.
  always_comb begin
    nextAddr = imemReqAddr;
    if (handshake) begin
      if (redirect)     nextAddr = target;
      else if (pending) nextAddr = pendingTarget;
      else              nextAddr = seqAddr;
    end else if (!held && redirect) begin
      nextAddr = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imemReqAddr   <= RESET_PC;
      pcOut         <= RESET_PC;
      pcPlus4Out    <= RESET_PC + XLEN'(4);
      flushOut      <= 1'b0;
      pending       <= 1'b0;
      pendingTarget <= '0;
    end else begin
      imemReqAddr <= nextAddr;
      flushOut    <= redirect;
      if (handshake) begin
        pcOut      <= imemReqAddr;
        pcPlus4Out <= seqAddr;
        pending    <= 1'b0;
      end else if (held && redirect) begin
        pending       <= 1'b1;
        pendingTarget <= target;
      end
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalignErr <= 1'b0;
    else        misalignErr <= jumpOrBranch & target[1];
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl, including a wrap-around instance (RESET_PC=0xFFFF_FFFC).
// Misalign checks are compiled in when PC_MISALIGN_CHK_EN is defined.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic        jb;
    logic        jalr;
    logic [31:0] brPc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        stall;
    logic        ready;
    logic        expValid;
    logic [31:0] expAddr;
    logic [31:0] expPc;
    logic [31:0] expPc4;
    logic        expFlush;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jumpOrBranch = 1'b0, jalrIn = 1'b0, stallIn = 1'b0, imemReqReady = 1'b1;
  logic [31:0] brPcIn = '0, immIn = '0, rs1In = '0;
  logic        imemReqValid, flushOut;
  logic [31:0] imemReqAddr, pcOut, pcPlus4Out;
  logic        wValid, wFlush;
  logic [31:0] wAddr, wPc, wPc4;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalignErr, wMisalignErr;
`endif

  int checkCount = 0;
  int failCount  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .jumpOrBranch(jumpOrBranch), .jalrIn(jalrIn),
    .brPcIn(brPcIn), .immIn(immIn), .rs1In(rs1In), .stallIn(stallIn),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .pcOut(pcOut), .pcPlus4Out(pcPlus4Out), .flushOut(flushOut)
`ifdef PC_MISALIGN_CHK_EN
    , .misalignErr(misalignErr)
`endif
  );

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .jumpOrBranch(jumpOrBranch), .jalrIn(jalrIn),
    .brPcIn(brPcIn), .immIn(immIn), .rs1In(rs1In), .stallIn(stallIn),
    .imemReqValid(wValid), .imemReqAddr(wAddr), .imemReqReady(imemReqReady),
    .pcOut(wPc), .pcPlus4Out(wPc4), .flushOut(wFlush)
`ifdef PC_MISALIGN_CHK_EN
    , .misalignErr(wMisalignErr)
`endif
  );

  function automatic vec_t mk(input logic jb, input logic jalr, input logic [31:0] br,
                              input logic [31:0] imm, input logic [31:0] rs1,
                              input logic stall, input logic ready, input logic ev,
                              input logic [31:0] ea, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.jb = jb; v.jalr = jalr; v.brPc = br; v.imm = imm; v.rs1 = rs1;
    v.stall = stall; v.ready = ready; v.expValid = ev; v.expAddr = ea;
    v.expPc = ep; v.expPc4 = ep + 32'd4; v.expFlush = ef;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    jumpOrBranch = v.jb; jalrIn = v.jalr; brPcIn = v.brPc; immIn = v.imm;
    rs1In = v.rs1; stallIn = v.stall; imemReqReady = v.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, ".valid"}, {31'd0, imemReqValid}, {31'd0, v.expValid});
    checkField({tag, ".addr"},  imemReqAddr, v.expAddr);
    checkField({tag, ".pc"},    pcOut, v.expPc);
    checkField({tag, ".pc4"},   pcPlus4Out, v.expPc4);
    checkField({tag, ".flush"}, {31'd0, flushOut}, {31'd0, v.expFlush});
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // jb jalr brPc imm rs1 stall ready | valid addr pc flush
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0000,32'h0000,0));            // BOOT -> REQ
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0004,32'h0000,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0008,32'h0004,0));
    vecs.push_back(mk(1,0,32'h100,32'hFFFF_FFF0,0, 0,1, 1,32'h00F0,32'h0008,1)); // branch
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h00F4,32'h00F0,0));
    vecs.push_back(mk(1,1,0,32'h10,32'h2001, 0,1, 1,32'h2010,32'h00F4,1));    // jalr
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h2014,32'h2010,0));
    vecs.push_back(mk(1,0,32'h40,0,0, 0,1, 1,32'h0040,32'h2014,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,32'h0040,32'h2014,0));                // held
    vecs.push_back(mk(1,0,32'h80,0,0, 0,0, 1,32'h0040,32'h2014,1));           // redirect while held
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,32'h0040,32'h2014,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0080,32'h0040,0));                // accept -> pending
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0084,32'h0080,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,32'h0084,32'h0080,0));
    vecs.push_back(mk(1,0,32'h300,0,0, 0,0, 1,32'h0084,32'h0080,1));
    vecs.push_back(mk(1,0,32'h400,0,0, 0,0, 1,32'h0084,32'h0080,1));          // youngest wins
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0400,32'h0084,0));
    vecs.push_back(mk(1,0,32'h10,0,0, 0,1, 1,32'h0010,32'h0400,1));
    vecs.push_back(mk(0,0,0,0,0, 1,1, 0,32'h0014,32'h0010,0));                // stall after 0x10
    vecs.push_back(mk(0,0,0,0,0, 1,1, 0,32'h0014,32'h0010,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0014,32'h0010,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0018,32'h0014,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1, 0,32'h001C,32'h0018,0));
    vecs.push_back(mk(1,0,32'h200,0,0, 1,1, 0,32'h0200,32'h0018,1));          // redirect in WAIT
    vecs.push_back(mk(0,0,0,0,0, 1,1, 0,32'h0200,32'h0018,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0200,32'h0018,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0204,32'h0200,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0, 1,32'h0204,32'h0200,0));                // stall keeps request
    vecs.push_back(mk(0,0,0,0,0, 1,1, 0,32'h0208,32'h0204,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0208,32'h0204,0));
    vecs.push_back(mk(1,0,32'h500,0,0, 0,0, 1,32'h0208,32'h0204,1));
    vecs.push_back(mk(1,0,32'h600,0,0, 0,1, 1,32'h0600,32'h0208,1));          // redirect + handshake
    vecs.push_back(mk(0,0,0,0,0, 0,1, 1,32'h0604,32'h0600,0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mk(0,0,0,0,0, 0,1, 0,32'h0,32'h0,0));
    checkField("wrapReset.addr", wAddr, 32'hFFFF_FFFC);
    checkField("wrapReset.pc4", wPc4, 32'h0000_0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-operation, sampled between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset", mk(0,0,0,0,0, 0,1, 0,32'h0,32'h0,0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(idle);
    checkField("wrap0.valid", {31'd0, wValid}, 32'd1);
    checkField("wrap0.addr", wAddr, 32'hFFFF_FFFC);
    checkOutput("post0", mk(0,0,0,0,0, 0,1, 1,32'h0,32'h0,0));
    applyStimulus(idle);
    checkField("wrap1.addr", wAddr, 32'h0000_0000);
    checkField("wrap1.pc", wPc, 32'hFFFF_FFFC);
    checkField("wrap1.pc4", wPc4, 32'h0000_0000);
    checkOutput("post1", mk(0,0,0,0,0, 0,1, 1,32'h4,32'h0,0));

`ifdef PC_MISALIGN_CHK_EN
    applyStimulus(mk(1,1,0,32'h2,32'h100, 0,1, 0,0,0,0));
    checkOutput("misalign", mk(0,0,0,0,0, 0,1, 1,32'h8,32'h4,0));
    checkField("misalign.err", {31'd0, misalignErr}, 32'd1);
    applyStimulus(idle);
    checkOutput("misalignAfter", mk(0,0,0,0,0, 0,1, 1,32'hC,32'h8,0));
    checkField("misalignAfter.err", {31'd0, misalignErr}, 32'd0);
`else
    applyStimulus(mk(1,1,0,32'h2,32'h100, 0,1, 0,0,0,0));
    checkOutput("bit1Target", mk(0,0,0,0,0, 0,1, 1,32'h102,32'h4,1));
    applyStimulus(idle);
    checkOutput("bit1After", mk(0,0,0,0,0, 0,1, 1,32'h106,32'h102,0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
